buffer_ptr_ctrl: RTL

//  Parametrised store/get pointer pair for the shared USB/CDL data buffer.

---
 rtl/buffer_ptr_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/buffer_ptr_ctrl.sv
// Store/get pointer pair for the shared USB/CDL data buffer: wrap-around addressing,
// occupancy, full/empty flags and sticky error reporting. Optional macro: BPC_WATERMARK_EN.
module buffer_ptr_ctrl #(
  parameter int unsigned DEPTH    = 64,
`ifdef BPC_WATERMARK_EN
  parameter int unsigned AF_LEVEL = 56,
  parameter int unsigned AE_LEVEL = 8,
`endif
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              store_rx_packet_data,
  input  logic              store_tx_data,
  input  logic              get_rx_data,
  input  logic              get_tx_packet_data,
  output logic [ADDR_W-1:0] store_ptr,
  output logic [ADDR_W-1:0] get_ptr,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err
`ifdef BPC_WATERMARK_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam logic [ADDR_W:0] PtrOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] DepthOcc = (ADDR_W + 1)'(DEPTH);

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic            overflow_err_q, overflow_err_d;
  logic            underflow_err_q, underflow_err_d;
  logic [ADDR_W:0] occupancy;
  logic            store_req, get_req;
  logic            store_acc, get_acc;

  assign occupancy = wptr_q - rptr_q;
  assign full      = (occupancy == DepthOcc);
  assign empty     = (occupancy == '0);

  always_comb begin
    store_req       = store_rx_packet_data | store_tx_data;
    get_req         = get_rx_data | get_tx_packet_data;
    store_acc       = store_req & ~full;
    get_acc         = get_req & ~empty;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    overflow_err_d  = overflow_err_q;
    underflow_err_d = underflow_err_q;
    if (clr) begin
      wptr_d          = '0;
      rptr_d          = '0;
      overflow_err_d  = 1'b0;
      underflow_err_d = 1'b0;
    end else begin
      if (store_acc) wptr_d = wptr_q + PtrOne;
      if (get_acc)   rptr_d = rptr_q + PtrOne;
      overflow_err_d  = overflow_err_q | (store_req & full);
      underflow_err_d = underflow_err_q | (get_req & empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign store_ptr        = wptr_q[ADDR_W-1:0];
  assign get_ptr          = rptr_q[ADDR_W-1:0];
  assign buffer_occupancy = occupancy;
  assign overflow_err     = overflow_err_q;
  assign underflow_err    = underflow_err_q;

`ifdef BPC_WATERMARK_EN
  localparam logic [ADDR_W:0] AfLevel = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AeLevel = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W:0] occupancy_d;
  logic            almost_full_q, almost_full_d;
  logic            almost_empty_q, almost_empty_d;

  // Judged on next-state occupancy so the watermarks change on the same edge as full/empty.
  always_comb begin
    occupancy_d    = wptr_d - rptr_d;
    almost_full_d  = (occupancy_d >= AfLevel);
    almost_empty_d = (occupancy_d <= AeLevel);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
